// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: word request/ready handshake between fetch and imem.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem, strobes fetched words into IF/ID.
// Define IF_FLUSH_EN to squash (NOP) the instruction returned or held when a redirect arrives.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Stall,
  input  logic                   Redirect,
  input  logic [31:0]            RedirectPC,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            instruction_out,
  output logic [31:0]            PCNow_out,
  output logic [31:0]            PCNext4_out,
  output logic                   Write_out
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic        wr_q, wr_d;

  logic        squash;
  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;
  logic [31:0] hold_pc4;
  logic [31:0] captured;
  logic [31:0] held;

`ifdef IF_FLUSH_EN
  assign squash = Redirect;
`else
  assign squash = 1'b0;
`endif

  assign redirect_pc = {RedirectPC[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;
  assign hold_pc4    = hold_pc_q + 32'd4;
  assign captured    = squash ? '0 : imem.imem_rdata;
  assign held        = squash ? '0 : hold_instr_q;

  // A delivered entry stays pending while Stall is high, so IF/ID never sees a write under stall.
  // New entries only load the output buses when Stall=0, i.e. when any pending one drains too.
  assign Write_out = wr_q & ~Stall & ~rst;

  // In DRAIN the abandoned address stays on the bus until its ready; pc_q already holds the target.
  assign imem.imem_req  = ~rst & (state_q != S_HOLD);
  assign imem.imem_addr = (state_q == S_DRAIN) ? drain_q : pc_q;

  assign instruction_out = out_instr_q;
  assign PCNow_out       = out_pc_q;
  assign PCNext4_out     = out_pc4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_d      = drain_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    wr_d         = wr_q & ~Write_out;

    case (state_q)
      S_REQ: begin
        if (imem.imem_ready) begin
          pc_d = Redirect ? redirect_pc : pc_inc;
          if (Stall) begin
            hold_instr_d = captured;
            hold_pc_d    = pc_q;
            state_d      = S_HOLD;
          end else begin
            out_instr_d = captured;
            out_pc_d    = pc_q;
            out_pc4_d   = pc_inc;
            wr_d        = 1'b1;
          end
        end else if (Redirect) begin
          drain_d = pc_q;
          pc_d    = redirect_pc;
          state_d = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (Redirect) begin
          pc_d = redirect_pc;
        end
        if (Stall) begin
          hold_instr_d = held;
        end else begin
          out_instr_d = held;
          out_pc_d    = hold_pc_q;
          out_pc4_d   = hold_pc4;
          wr_d        = 1'b1;
          state_d     = S_REQ;
        end
      end

      S_DRAIN: begin
        if (Redirect) begin
          pc_d = redirect_pc;
        end
        if (imem.imem_ready) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drain_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_pc4_q    <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_q      <= drain_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      wr_q         <= wr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios then random stall/redirect/reset
// traffic against a transaction-level model with a random-latency instruction memory.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] instruction_out;
  logic [31:0] PCNow_out;
  logic [31:0] PCNext4_out;
  logic        Write_out;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectPC      (RedirectPC),
    .imem            (bus),
    .instruction_out (instruction_out),
    .PCNow_out       (PCNow_out),
    .PCNext4_out     (PCNext4_out),
    .Write_out       (Write_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: next fetch address, at most one parked entry, an optional abandoned
  // read, and the entry currently shown on the IF/ID buses with its pending flag.
  logic [31:0] m_pc;
  logic [31:0] m_dis_addr;
  bit          m_dis;
  entry_t      m_held[$];
  entry_t      m_vis;
  bit          m_pend;

  // Memory model state.
  bit          mem_busy;
  int unsigned mem_wait;
  int unsigned wait_lo;
  int unsigned wait_hi;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = RESET_PC;
    m_dis_addr = '0;
    m_dis      = 1'b0;
    m_held.delete();
    m_vis      = '{instr: '0, pc: '0, pc4: '0};
    m_pend     = 1'b0;
  endtask

  task automatic show(input entry_t e);
    m_vis      = e;
    m_vis.pc4  = e.pc + 32'd4;
    m_pend     = 1'b1;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    entry_t      e;
    logic        rdy;
    logic [31:0] rd;
    logic [31:0] tgt;
    logic        exp_req;
    logic        exp_wr;

    rst        = r;
    Stall      = s;
    Redirect   = d;
    RedirectPC = t;
    #1;

    exp_req = !r && (m_held.size() == 0);
    exp_wr  = m_pend && !s && !r;
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", bus.imem_addr, m_dis ? m_dis_addr : m_pc);
    check("Write_out", 32'(Write_out), 32'(exp_wr));
    check("instruction_out", instruction_out, m_vis.instr);
    check("PCNow_out", PCNow_out, m_vis.pc);
    check("PCNext4_out", PCNext4_out, m_vis.pc4);

    rdy = 1'b0;
    rd  = $urandom;
    if (bus.imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = $urandom_range(wait_hi, wait_lo);
      end
      if (mem_wait == 0) begin
        rdy      = 1'b1;
        rd       = mem_word(bus.imem_addr);
        mem_busy = 1'b0;
      end else begin
        mem_wait--;
      end
    end else begin
      rdy = ($urandom_range(0, 3) == 0);
    end
    if (r) mem_busy = 1'b0;
    bus.imem_ready = rdy;
    bus.imem_rdata = rd;

    if (exp_wr) m_pend = 1'b0;
    tgt = {t[31:2], 2'b00};
    if (r) begin
      model_reset();
    end else if (m_held.size() != 0) begin
      e = m_held.pop_front();
      if (d) begin
        m_pc = tgt;
        if (FLUSH) e.instr = '0;
      end
      if (!s) show(e);
      else    m_held.push_back(e);
    end else if (m_dis) begin
      if (d)   m_pc  = tgt;
      if (rdy) m_dis = 1'b0;
    end else if (rdy) begin
      e.instr = (d && FLUSH) ? 32'h0 : mem_word(m_pc);
      e.pc    = m_pc;
      e.pc4   = '0;
      m_pc    = d ? tgt : m_pc + 32'd4;
      if (s) m_held.push_back(e);
      else   show(e);
    end else if (d) begin
      m_dis      = 1'b1;
      m_dis_addr = m_pc;
      m_pc       = tgt;
    end

    @(negedge clk);
  endtask

  task automatic run(input int unsigned n, input int unsigned lo, input int unsigned hi);
    wait_lo = lo;
    wait_hi = hi;
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    rst            = 1'b1;
    Stall          = 1'b0;
    Redirect       = 1'b0;
    RedirectPC     = '0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    mem_busy       = 1'b0;
    mem_wait       = 0;
    wait_lo        = 0;
    wait_hi        = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(6, 0, 0);
    run(8, 3, 3);

    // Stall landing on a zero-wait ready, then release.
    wait_lo = 0; wait_hi = 0;
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    run(3, 0, 0);

    // Redirect while a slow read is pending, then one coincident with a ready.
    wait_lo = 2; wait_hi = 2;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0101);
    run(6, 0, 0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    run(3, 0, 0);

    // Redirect into a held entry, then PC wrap-around.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
    run(3, 0, 0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9);
    run(4, 0, 0);

    // Reset asserted while holding, and while draining.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    run(2, 0, 0);
    wait_lo = 3; wait_hi = 3;
    step(1'b0, 1'b0, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(6, 0, 1);

    for (int unsigned i = 0; i < 4000; i++) begin
      wait_lo = 0;
      wait_hi = 3;
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       tgt = RESET_PC + 32'($urandom_range(0, 63));
        default: tgt = $urandom;
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), tgt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
